// File: rtl/mem_wr_arb_if.sv
// -----------------------------------------------------------------------------
// mem_wr_arb_if
//
// Bundle of the request lanes feeding the mem-queue write arbiter and the
// write/size-report port the arbiter drives toward the mem queue.
//
//   req_valid          per-lane request, held until acked
//   req_read_num       per-lane read number, lane i at [i*READ_NUM_WIDTH +: READ_NUM_WIDTH]
//   req_data           per-lane 256-bit mem entry, lane i at [i*256 +: 256]
//   req_keep           1 = request carries an entry to write, 0 = size report only
//   req_last           1 = final request for this read, a size report follows
//   req_ack            one-hot grant back to the lanes (combinational)
//   mem_we_1           mem-queue write enable (registered pulse)
//   mem_read_num_1     read number of the write
//   mem_addr_1         slot index of the write within its read
//   mem_data_1         write data
//   mem_size_valid     size report pulse (registered)
//   mem_size           final entry count of the reported read
//   mem_size_read_num  read number of the size report
//
// The master modport is the lane side (pipeline / testbench), the slave
// modport is the arbiter.
// -----------------------------------------------------------------------------
interface mem_wr_arb_if #(
    parameter int NUM_REQ        = 4,
    parameter int READ_NUM_WIDTH = 6
);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ*READ_NUM_WIDTH-1:0] req_read_num;
    logic [NUM_REQ*256-1:0]            req_data;
    logic [NUM_REQ-1:0]                req_keep;
    logic [NUM_REQ-1:0]                req_last;
    logic [NUM_REQ-1:0]                req_ack;

    logic                              mem_we_1;
    logic [READ_NUM_WIDTH-1:0]         mem_read_num_1;
    logic [6:0]                        mem_addr_1;
    logic [255:0]                      mem_data_1;

    logic                              mem_size_valid;
    logic [6:0]                        mem_size;
    logic [READ_NUM_WIDTH-1:0]         mem_size_read_num;

    // Lane side: raises requests, sees the grant and the mem-queue traffic.
    modport master (
        output req_valid,
        output req_read_num,
        output req_data,
        output req_keep,
        output req_last,
        input  req_ack,
        input  mem_we_1,
        input  mem_read_num_1,
        input  mem_addr_1,
        input  mem_data_1,
        input  mem_size_valid,
        input  mem_size,
        input  mem_size_read_num
    );

    // Arbiter side: consumes requests, drives the grant and the write port.
    modport slave (
        input  req_valid,
        input  req_read_num,
        input  req_data,
        input  req_keep,
        input  req_last,
        output req_ack,
        output mem_we_1,
        output mem_read_num_1,
        output mem_addr_1,
        output mem_data_1,
        output mem_size_valid,
        output mem_size,
        output mem_size_read_num
    );

endinterface

// File: rtl/mem_wr_arb.sv
// -----------------------------------------------------------------------------
// mem_wr_arb
//
// Round-robin arbiter that lets NUM_REQ SMEM pipeline lanes share the single
// mem-queue write port. Each read owns READ_MAX_MEM slots in the mem queue; a
// per-read counter hands out slot addresses in order. Entries beyond the
// last slot are dropped and flagged through the sticky overflow bit. A
// request marked last makes the arbiter report the read's final entry count
// and recycle its counter for the next use of that read number.
//
// Ports
//   clk          clock, everything on the rising edge
//   reset_n      synchronous, active-low reset
//   batch_start  one-cycle pulse: clears all read counters and overflow,
//                and suppresses any grant in the same cycle
//   stall        while high no new grant is issued
//   bus          mem_wr_arb_if slave: lane requests in, grant and
//                mem-queue write / size report out
//   overflow     sticky flag, an entry was dropped because its read was full
//
// Timing: the grant (req_ack) is combinational in the request cycle; the
// write and the size report caused by that request appear together one
// cycle later on registered outputs.
// -----------------------------------------------------------------------------
module mem_wr_arb #(
    parameter int NUM_REQ        = 4,
    parameter int READ_MAX_MEM   = 40,
    parameter int READ_NUM_WIDTH = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           batch_start,
    input  logic           stall,
    mem_wr_arb_if.slave    bus,
    output logic           overflow
);

    localparam int               NUM_READS = 1 << READ_NUM_WIDTH;
    localparam int               LANE_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [6:0]       MAX_CNT   = 7'(READ_MAX_MEM);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_REQ - 1);

    // Round-robin pointer: the lane granted most recently.
    logic [LANE_W-1:0]         last_grant;

    // Arbitration results for the current cycle.
    logic [LANE_W-1:0]         rr_cand;
    logic                      grant_found;
    logic [LANE_W-1:0]         grant_lane;
    logic                      grant;

    // Payload of the granted lane.
    logic [READ_NUM_WIDTH-1:0] sel_read_num;
    logic [255:0]              sel_data;
    logic                      sel_keep;
    logic                      sel_last;

    // Per-read slot counters and the decision for the granted request.
    logic [6:0]                cnt [NUM_READS];
    logic [6:0]                cur_cnt;
    logic                      do_write;
    logic                      do_drop;
    logic [6:0]                cnt_after;

    // Search the lanes starting just after the last granted one and take the
    // first lane that is requesting. Walking k = 1..NUM_REQ from last_grant
    // visits every lane exactly once, ending on last_grant itself, so a lone
    // requester is always found and the lane just served has lowest priority.
    always_comb begin
        rr_cand     = '0;
        grant_found = 1'b0;
        grant_lane  = last_grant;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = LANE_W'((int'(last_grant) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[rr_cand]) begin
                grant_found = 1'b1;
                grant_lane  = rr_cand;
            end
        end
    end

    // A grant only happens when the block is out of reset, not stalled, and
    // not being cleared by batch_start; the clear wins over a same-cycle
    // request so the lane simply retries once the counters are fresh.
    always_comb begin
        grant = grant_found && reset_n && !stall && !batch_start;
    end

    // The acknowledge is a one-hot decode of the winning lane, driven in the
    // same cycle so the lane can move on to its next request immediately.
    always_comb begin
        bus.req_ack = '0;
        if (grant) begin
            bus.req_ack[grant_lane] = 1'b1;
        end
    end

    // Pull the granted lane's payload out of the flat request buses.
    always_comb begin
        sel_read_num = bus.req_read_num[int'(grant_lane)*READ_NUM_WIDTH +: READ_NUM_WIDTH];
        sel_data     = bus.req_data[int'(grant_lane)*256 +: 256];
        sel_keep     = bus.req_keep[grant_lane];
        sel_last     = bus.req_last[grant_lane];
    end

    // Decide what the granted request does to its read. The counter array is
    // updated on the same edge as the grant, so a second request to the same
    // read in the very next cycle already sees the incremented count and gets
    // the following slot without any extra forwarding path. A full read keeps
    // its count and the entry is dropped.
    always_comb begin
        cur_cnt   = cnt[sel_read_num];
        do_write  = sel_keep && (cur_cnt < MAX_CNT);
        do_drop   = sel_keep && !do_write;
        cnt_after = do_write ? (cur_cnt + 7'd1) : cur_cnt;
    end

    // The round-robin pointer moves only when a lane is actually granted, so
    // stalled or idle cycles do not disturb the fairness order. Reset points
    // it at the last lane, which gives lane 0 first priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= LAST_LANE;
        end else if (grant) begin
            last_grant <= grant_lane;
        end
    end

    // Per-read slot counters. batch_start wipes every read. A granted request
    // stores its post-write count, except a last request, which recycles the
    // read number by clearing its counter after the size has been captured.
    always_ff @(posedge clk) begin
        if (!reset_n || batch_start) begin
            for (int r = 0; r < NUM_READS; r++) begin
                cnt[r] <= 7'd0;
            end
        end else if (grant) begin
            if (sel_last) begin
                cnt[sel_read_num] <= 7'd0;
            end else begin
                cnt[sel_read_num] <= cnt_after;
            end
        end
    end

    // Mem-queue write port. The enable is a single-cycle pulse that follows
    // a granted keep request with room in its read; address, read number and
    // data hold their last values between writes. Reset clears everything,
    // which also drops a write that was about to be presented.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.mem_we_1       <= 1'b0;
            bus.mem_read_num_1 <= '0;
            bus.mem_addr_1     <= 7'd0;
            bus.mem_data_1     <= '0;
        end else begin
            bus.mem_we_1 <= grant && do_write;
            if (grant && do_write) begin
                bus.mem_read_num_1 <= sel_read_num;
                bus.mem_addr_1     <= cur_cnt;
                bus.mem_data_1     <= sel_data;
            end
        end
    end

    // Size report port. It fires in the same cycle as the write from the same
    // last request, and the count it reports already includes that write
    // (or excludes a dropped entry).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.mem_size_valid    <= 1'b0;
            bus.mem_size          <= 7'd0;
            bus.mem_size_read_num <= '0;
        end else begin
            bus.mem_size_valid <= grant && sel_last;
            if (grant && sel_last) begin
                bus.mem_size          <= cnt_after;
                bus.mem_size_read_num <= sel_read_num;
            end
        end
    end

    // Overflow is sticky for the whole batch: any dropped entry sets it and
    // only reset or the next batch_start clears it.
    always_ff @(posedge clk) begin
        if (!reset_n || batch_start) begin
            overflow <= 1'b0;
        end else if (grant && do_drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_wr_arb
//
// Self-checking bench for mem_wr_arb. A behavioural model (per-read counts in
// an int array, round-robin pick by modular search) predicts the grant and
// the registered outputs every cycle. On top of that a vector table covers
// ordered grants, stall and size reporting, and hand-written sequences cover
// the full-read, overflow, batch_start and reset corner cases before a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_mem_wr_arb;

    localparam int NL  = 4;
    localparam int RW  = 6;
    localparam int MAX = 40;

    logic clk;
    logic reset_n;
    logic batch_start;
    logic stall;
    logic overflow;

    mem_wr_arb_if #(.NUM_REQ(NL), .READ_NUM_WIDTH(RW)) bus ();

    mem_wr_arb #(
        .NUM_REQ        (NL),
        .READ_MAX_MEM   (MAX),
        .READ_NUM_WIDTH (RW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .batch_start (batch_start),
        .stall       (stall),
        .bus         (bus.slave),
        .overflow    (overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane-side stimulus state, packed onto the bus by applyStimulus.
    logic [NL-1:0] lane_valid;
    logic [RW-1:0] lane_rn [NL];
    logic [255:0]  lane_data [NL];
    logic [NL-1:0] lane_keep;
    logic [NL-1:0] lane_last;

    // Reference model state.
    int     m_cnt [64];
    int     m_last;
    bit     m_ovf;
    bit     e_we;
    bit     e_sv;
    bit     e_zero;
    int     e_addr;
    int     e_rn;
    int     e_size;
    int     e_size_rn;
    logic [255:0] e_data;

    logic [NL-1:0] last_ack;
    int            last_lane;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] valid;
        logic [5:0] rn;
        logic [3:0] keep;
        logic [3:0] last;
        logic       stall;
        logic       batch;
        logic [3:0] exp_ack;
        logic       exp_we;
        logic [6:0] exp_addr;
        logic       exp_sv;
        logic [6:0] exp_size;
    } vec_t;

    vec_t vecs [16];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus();
        bus.req_valid = lane_valid;
        bus.req_keep  = lane_keep;
        bus.req_last  = lane_last;
        for (int i = 0; i < NL; i++) begin
            bus.req_read_num[i*RW +: RW] = lane_rn[i];
            bus.req_data[i*256 +: 256]   = lane_data[i];
        end
    endtask

    function automatic int pick_lane(input logic [NL-1:0] v, input int lg);
        for (int k = 1; k <= NL; k++) begin
            if (v[(lg + k) % NL]) return (lg + k) % NL;
        end
        return -1;
    endfunction

    function automatic int lane_of(input logic [3:0] onehot);
        for (int i = 0; i < NL; i++) begin
            if (onehot[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [255:0] mk_data(input int lane, input int row);
        logic [31:0] w;
        w = 32'hD000_0000 | 32'(row << 8) | 32'(lane);
        return {8{w}};
    endfunction

    // One clock cycle: drive inputs (called at posedge+1), check the
    // combinational grant mid-cycle, advance the model, then check the
    // registered outputs at posedge+1.
    task automatic run_cycle();
        int g;
        int r;
        logic [NL-1:0] exp_ack;
        applyStimulus();
        #3;
        g = -1;
        if (reset_n && !stall && !batch_start) g = pick_lane(lane_valid, m_last);
        exp_ack = (g >= 0) ? NL'(1 << g) : '0;
        checkOutput("req_ack", bus.req_ack, exp_ack);
        last_ack  = bus.req_ack;
        last_lane = g;

        e_we   = 0;
        e_sv   = 0;
        e_zero = 0;
        if (!reset_n) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_last = NL - 1;
            m_ovf  = 0;
            e_zero = 1;
        end else if (batch_start) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_ovf = 0;
        end else if (g >= 0) begin
            r      = int'(lane_rn[g]);
            m_last = g;
            if (lane_keep[g]) begin
                if (m_cnt[r] < MAX) begin
                    e_we   = 1;
                    e_addr = m_cnt[r];
                    e_rn   = r;
                    e_data = lane_data[g];
                    m_cnt[r]++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (lane_last[g]) begin
                e_sv      = 1;
                e_size    = m_cnt[r];
                e_size_rn = r;
                m_cnt[r]  = 0;
            end
        end

        @(posedge clk);
        #1;
        checkOutput("mem_we_1", bus.mem_we_1, e_we);
        checkOutput("mem_size_valid", bus.mem_size_valid, e_sv);
        checkOutput("overflow", overflow, m_ovf);
        if (e_we) begin
            checkOutput("mem_addr_1", bus.mem_addr_1, e_addr);
            checkOutput("mem_read_num_1", bus.mem_read_num_1, e_rn);
            checkOutput("mem_data_1", bus.mem_data_1, e_data);
        end
        if (e_sv) begin
            checkOutput("mem_size", bus.mem_size, e_size);
            checkOutput("mem_size_read_num", bus.mem_size_read_num, e_size_rn);
        end
        if (e_zero) begin
            checkOutput("reset_addr", bus.mem_addr_1, 0);
            checkOutput("reset_data", bus.mem_data_1, 0);
            checkOutput("reset_rn", bus.mem_read_num_1, 0);
            checkOutput("reset_size", bus.mem_size, 0);
            checkOutput("reset_size_rn", bus.mem_size_read_num, 0);
        end
    endtask

    task automatic set_single(input int lane, input int rn, input bit keep, input bit last);
        lane_valid       = '0;
        lane_keep        = '0;
        lane_last        = '0;
        lane_valid[lane] = 1'b1;
        lane_rn[lane]    = RW'(rn);
        lane_keep[lane]  = keep;
        lane_last[lane]  = last;
        lane_data[lane]  = {$urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        m_last      = NL - 1;
        m_ovf       = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;

        // valid, rn, keep, last, stall, batch | ack, we, addr, sv, size
        vecs[0]  = '{4'b1111, 6'd5, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 7'd0, 1'b0, 7'd0};
        vecs[1]  = '{4'b1110, 6'd5, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 7'd1, 1'b0, 7'd0};
        vecs[2]  = '{4'b1100, 6'd5, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 7'd2, 1'b0, 7'd0};
        vecs[3]  = '{4'b1000, 6'd5, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 7'd3, 1'b0, 7'd0};
        vecs[4]  = '{4'b0011, 6'd6, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 7'd0, 1'b0, 7'd0};
        vecs[5]  = '{4'b0011, 6'd6, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 7'd0, 1'b0, 7'd0};
        vecs[6]  = '{4'b0011, 6'd6, 4'b1111, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 7'd0, 1'b0, 7'd0};
        vecs[7]  = '{4'b0011, 6'd6, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 7'd0, 1'b0, 7'd0};
        vecs[8]  = '{4'b0010, 6'd6, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 7'd1, 1'b0, 7'd0};
        vecs[9]  = '{4'b0001, 6'd9, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0, 7'd0, 1'b1, 7'd0};
        vecs[10] = '{4'b0100, 6'd6, 4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 7'd2, 1'b1, 7'd3};
        vecs[11] = '{4'b1000, 6'd6, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 7'd0, 1'b0, 7'd0};
        vecs[12] = '{4'b1001, 6'd5, 4'b1001, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 7'd4, 1'b0, 7'd0};
        vecs[13] = '{4'b1000, 6'd5, 4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 7'd5, 1'b0, 7'd0};
        vecs[14] = '{4'b0110, 6'd5, 4'b0110, 4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 7'd6, 1'b0, 7'd0};
        vecs[15] = '{4'b0100, 6'd5, 4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1, 7'd7, 1'b0, 7'd0};

        reset_n     = 1'b0;
        batch_start = 1'b0;
        stall       = 1'b0;
        lane_valid  = 4'b1111;
        lane_keep   = 4'b1111;
        lane_last   = 4'b0000;
        for (int i = 0; i < NL; i++) begin
            lane_rn[i]   = RW'(i);
            lane_data[i] = mk_data(i, 99);
        end

        @(posedge clk);
        #1;
        $display("[TB] reset phase");
        run_cycle();
        run_cycle();
        reset_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 16; i++) begin
            lane_valid  = vecs[i].valid;
            lane_keep   = vecs[i].keep;
            lane_last   = vecs[i].last;
            stall       = vecs[i].stall;
            batch_start = vecs[i].batch;
            for (int l = 0; l < NL; l++) begin
                lane_rn[l]   = vecs[i].rn;
                lane_data[l] = mk_data(l, i);
            end
            run_cycle();
            checkOutput("vec_ack", last_ack, vecs[i].exp_ack);
            checkOutput("vec_we", bus.mem_we_1, vecs[i].exp_we);
            checkOutput("vec_sv", bus.mem_size_valid, vecs[i].exp_sv);
            if (vecs[i].exp_we) begin
                checkOutput("vec_addr", bus.mem_addr_1, vecs[i].exp_addr);
                checkOutput("vec_rn", bus.mem_read_num_1, vecs[i].rn);
                checkOutput("vec_data", bus.mem_data_1, mk_data(lane_of(vecs[i].exp_ack), i));
            end
            if (vecs[i].exp_sv) begin
                checkOutput("vec_size", bus.mem_size, vecs[i].exp_size);
                checkOutput("vec_size_rn", bus.mem_size_read_num, vecs[i].rn);
            end
        end
        stall       = 1'b0;
        batch_start = 1'b0;

        $display("[TB] full read 7 on lane 2");
        for (int i = 0; i < MAX - 1; i++) begin
            set_single(2, 7, 1'b1, 1'b0);
            run_cycle();
        end
        set_single(2, 7, 1'b1, 1'b1);
        run_cycle();
        checkOutput("full_we", bus.mem_we_1, 1);
        checkOutput("full_addr", bus.mem_addr_1, 39);
        checkOutput("full_sv", bus.mem_size_valid, 1);
        checkOutput("full_size", bus.mem_size, 40);
        checkOutput("full_size_rn", bus.mem_size_read_num, 7);
        set_single(2, 7, 1'b1, 1'b0);
        run_cycle();
        checkOutput("full_cleared_addr", bus.mem_addr_1, 0);

        $display("[TB] overflow on read 3");
        for (int i = 0; i < MAX; i++) begin
            set_single(1, 3, 1'b1, 1'b0);
            run_cycle();
        end
        checkOutput("ovf_before", overflow, 0);
        set_single(1, 3, 1'b1, 1'b0);
        run_cycle();
        checkOutput("ovf_ack", last_ack, 4'b0010);
        checkOutput("ovf_we", bus.mem_we_1, 0);
        checkOutput("ovf_flag", overflow, 1);
        set_single(1, 3, 1'b0, 1'b1);
        run_cycle();
        checkOutput("ovf_size_valid", bus.mem_size_valid, 1);
        checkOutput("ovf_size", bus.mem_size, 40);
        checkOutput("ovf_sticky", overflow, 1);

        $display("[TB] batch_start against a lane 0 request");
        set_single(0, 5, 1'b1, 1'b0);
        batch_start = 1'b1;
        run_cycle();
        batch_start = 1'b0;
        checkOutput("batch_ack", last_ack, 4'b0000);
        checkOutput("batch_we", bus.mem_we_1, 0);
        checkOutput("batch_ovf", overflow, 0);
        run_cycle();
        checkOutput("batch_next_ack", last_ack, 4'b0001);
        checkOutput("batch_next_addr", bus.mem_addr_1, 0);
        checkOutput("batch_next_rn", bus.mem_read_num_1, 5);

        $display("[TB] reset during a pending output");
        set_single(0, 2, 1'b1, 1'b1);
        run_cycle();
        checkOutput("pend_we", bus.mem_we_1, 1);
        reset_n       = 1'b0;
        lane_valid    = 4'b1010;
        lane_keep     = 4'b1010;
        lane_last     = 4'b0000;
        lane_rn[1]    = 6'd2;
        lane_rn[3]    = 6'd2;
        run_cycle();
        checkOutput("rst_ack", last_ack, 4'b0000);
        checkOutput("rst_we", bus.mem_we_1, 0);
        checkOutput("rst_sv", bus.mem_size_valid, 0);
        reset_n    = 1'b1;
        lane_valid = 4'b1001;
        lane_keep  = 4'b1001;
        lane_rn[0] = 6'd2;
        run_cycle();
        checkOutput("rst_first_lane0", last_ack, 4'b0001);

        $display("[TB] randomized phase");
        lane_valid = '0;
        for (int c = 0; c < 800; c++) begin
            for (int l = 0; l < NL; l++) begin
                if (!lane_valid[l] && ($urandom_range(0, 1) == 1)) begin
                    lane_valid[l] = 1'b1;
                    lane_rn[l]    = RW'($urandom_range(0, 3));
                    lane_keep[l]  = ($urandom_range(0, 99) < 85);
                    lane_last[l]  = ($urandom_range(0, 99) < 3);
                    lane_data[l]  = {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom};
                end
            end
            stall       = ($urandom_range(0, 99) < 15);
            batch_start = ($urandom_range(0, 99) < 2);
            run_cycle();
            if (last_lane >= 0) lane_valid[last_lane] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
